// File: rtl/fourbee_pkg.sv
// Shared definitions for the program loader.
// Contents:
//   PROG_DEPTH      number of program words
//   WORD_W          program word width in bits
//   ADDR_W          program memory address width
//   loader_state_e  loader FSM state encoding
package fourbee_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int WORD_W     = 4;
  localparam int ADDR_W     = $clog2(PROG_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CKSUM,
    ST_VERIFY,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Bundle of the loader's control, serial-link and program-memory signals.
// Signals:
//   start                 one-cycle load request
//   ser_valid / ser_bit   serial link bit and its qualifier
//   ser_ready             loader accepts a bit this cycle
//   mem_addr / mem_data   program memory address and write data
//   mem_we                program memory write enable
//   mem_rdata             program memory registered read data
//   busy / done / ok      loader status
// Modports:
//   master  board/programming side (drives link, returns memory read data)
//   slave   the loader itself
interface prog_loader_if
  import fourbee_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH,
  parameter int DW    = WORD_W
) ();

  localparam int AW = $clog2(DEPTH);

  logic          start;
  logic          ser_valid;
  logic          ser_bit;
  logic          ser_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          ok;

  modport master (
    output start, ser_valid, ser_bit, mem_rdata,
    input  ser_ready, mem_addr, mem_data, mem_we, busy, done, ok
  );

  modport slave (
    input  start, ser_valid, ser_bit, mem_rdata,
    output ser_ready, mem_addr, mem_data, mem_we, busy, done, ok
  );

endinterface

// File: rtl/prog_loader_nibble_deser.sv
// Serial-to-parallel word assembler, MSB first.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   shift       accept din into the LSB, pushing earlier bits up
//   clear       empty the register and bit counter
//   din         serial data bit
//   word        assembled word (held while shift is low)
//   full        W-1 bits held: the next shift completes the word
module nibble_deser
  import fourbee_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift,
  input  logic         clear,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [W-1:0]  word_reg;
  logic [CW-1:0] count_reg;

  // The counter wraps to zero on the completing shift, so back-to-back
  // words need no explicit clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      word_reg  <= '0;
      count_reg <= '0;
    end else if (shift) begin
      word_reg  <= {word_reg[W-2:0], din};
      count_reg <= count_reg + 1'b1;
    end
  end

  assign word = word_reg;
  assign full = (count_reg == LAST_BIT);

endmodule

// File: rtl/prog_loader.sv
// Bit-serial program loader: receives DEPTH words MSB-first, writes each
// into program memory, receives an XOR checksum, reads every word back
// and reports whether the readback XOR matches.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         prog_loader_if slave: start, serial link, memory port, status
module prog_loader
  import fourbee_pkg::*;
#(
  parameter int DEPTH = PROG_DEPTH,
  parameter int DW    = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_RD   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   VERIFY_END = (AW+1)'(DEPTH);

  loader_state_e state_reg;
  logic [AW-1:0] index_reg;
  logic [AW-1:0] addr_reg;
  logic [AW:0]   vcnt_reg;
  logic [DW-1:0] cksum_reg;
  logic [DW-1:0] acc_reg;
  logic          we_reg;
  logic          ready_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          ok_reg;

  logic          xfer;
  logic          start_accept;
  logic [DW-1:0] word;
  logic          full;

  assign xfer         = bus.ser_valid && ready_reg;
  assign start_accept = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // One assembler serves both program words and the checksum; its output
  // doubles as the memory write data, and it holds steady during WRITE
  // because ser_ready is low there.
  nibble_deser #(.W(DW)) u_deser (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (xfer),
    .clear (start_accept),
    .din   (bus.ser_bit),
    .word  (word),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
      addr_reg  <= '0;
      vcnt_reg  <= '0;
      cksum_reg <= '0;
      acc_reg   <= '0;
      we_reg    <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          addr_reg <= '0;
          if (bus.start) begin
            state_reg <= ST_RECV;
            index_reg <= '0;
            cksum_reg <= '0;
            acc_reg   <= '0;
            done_reg  <= 1'b0;
            ok_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b1;
          end
        end
        ST_RECV: begin
          if (xfer && full) begin
            state_reg <= ST_WRITE;
            ready_reg <= 1'b0;
            we_reg    <= 1'b1;
            addr_reg  <= index_reg;
          end
        end
        ST_WRITE: begin
          we_reg    <= 1'b0;
          addr_reg  <= '0;
          ready_reg <= 1'b1;
          // Last-word test uses the index before any increment.
          if (index_reg == LAST_IDX) begin
            state_reg <= ST_CKSUM;
          end else begin
            index_reg <= index_reg + 1'b1;
            state_reg <= ST_RECV;
          end
        end
        ST_CKSUM: begin
          if (xfer && full) begin
            state_reg <= ST_VERIFY;
            ready_reg <= 1'b0;
            addr_reg  <= '0;
            vcnt_reg  <= '0;
          end
        end
        ST_VERIFY: begin
          // vcnt k: address min(k, DEPTH-1) is on the bus, and from k=1
          // the read data belongs to address k-1.
          vcnt_reg <= vcnt_reg + 1'b1;
          if (vcnt_reg == '0) begin
            cksum_reg <= word;
          end else begin
            acc_reg <= acc_reg ^ bus.mem_rdata;
          end
          if (vcnt_reg < LAST_RD) begin
            addr_reg <= addr_reg + 1'b1;
          end
          if (vcnt_reg == VERIFY_END) begin
            state_reg <= ST_DONE;
            addr_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            ok_reg    <= ((acc_reg ^ bus.mem_rdata) == cksum_reg);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ser_ready = ready_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_data  = word;
  assign bus.mem_we    = we_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.ok        = ok_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads with a behavioural
// 16x4 program memory (registered read). Stimulus pushes expected writes
// and verify results into queues; a negedge monitor pops and compares.
module tb_prog_loader;
  import fourbee_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // program memory model
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] addr; logic [3:0] data; } wr_t;
  typedef struct { logic ok; int edge_at; } res_t;
  wr_t  wr_q [$];
  res_t res_q [$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.ser_ready, bus.mem_we, bus.mem_addr, bus.mem_data,
            bus.busy, bus.done, bus.ok};
  endfunction

  // monitor / scoreboard
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, required no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", int'(bus.mem_addr), int'(w.addr));
        check("write_data", int'(bus.mem_data), int'(w.data));
        $display("write addr=%0d data=%0h", bus.mem_addr, bus.mem_data);
      end
    end
    if (bus.done && !done_prev) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: ok=%0b, required no done", bus.ok);
      end else begin
        r = res_q.pop_front();
        check("verify_ok", int'(bus.ok), int'(r.ok));
        if (r.edge_at >= 0) check("done_edge", cyc, r.edge_at);
        $display("verify done ok=%0b at edge %0d", bus.ok, cyc);
      end
    end
    done_prev <= bus.done;
  end

  task automatic send_bit(input logic b, input int maxgap);
    int n;
    bus.ser_valid = 1'b0;
    repeat ($urandom_range(0, maxgap)) begin
      @(posedge clk);
      #1;
    end
    n = 0;
    while (!bus.ser_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.ser_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ser_ready=0 after %0d cycles, required 1", n);
    end
    bus.ser_valid = 1'b1;
    bus.ser_bit   = b;
    @(posedge clk);
    #1;
    bus.ser_valid = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] v, input int maxgap);
    for (int b = 3; b >= 0; b--) send_bit(v[b], maxgap);
  endtask

  // Full load of 16 words (word i = words[4i+3:4i]) plus checksum.
  task automatic run_load(input logic [63:0] words, input logic [3:0] cks,
                          input int maxgap, input logic exp_ok,
                          input bit timed, input bit poke_start);
    int n;
    int s_edge;
    for (int i = 0; i < 16; i++)
      wr_q.push_back('{addr: 4'(i), data: words[i*4 +: 4]});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    s_edge = cyc;
    check("start_busy", int'(bus.busy), 1);
    check("start_ready", int'(bus.ser_ready), 1);
    check("start_done_clr", int'(bus.done), 0);
    check("start_ok_clr", int'(bus.ok), 0);
    // 84 edges of load + 17 verify edges; done rises on the last of them.
    res_q.push_back('{ok: exp_ok, edge_at: timed ? s_edge + 101 : -1});
    for (int i = 0; i < 16; i++) begin
      if (poke_start && i == 5) bus.start = 1'b1;
      send_nibble(words[i*4 +: 4], maxgap);
      bus.start = 1'b0;
    end
    send_nibble(cks, maxgap);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 16; i++) check("mem_word", int'(mem[i]), int'(words[i*4 +: 4]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i % 25 == 24) check("idle_outputs", int'(outs()), 0);
    end
    $display("idle check complete");

    // 0..F, checksum 0 -> ok
    run_load(64'hFEDC_BA98_7654_3210, 4'h0, 0, 1'b1, 1'b1, 1'b0);
    // same words, wrong checksum -> not ok; restarts from DONE
    run_load(64'hFEDC_BA98_7654_3210, 4'h5, 0, 1'b0, 1'b1, 1'b0);
    // all 0xA with random gaps -> ok
    run_load(64'hAAAA_AAAA_AAAA_AAAA, 4'h0, 7, 1'b1, 1'b0, 1'b0);

    // partial load of 0x3 interrupted by reset during the 7th WRITE
    for (int i = 0; i < 7; i++) wr_q.push_back('{addr: 4'(i), data: 4'h3});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) send_nibble(4'h3, 0);
    check("partial_we", int'(bus.mem_we), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_outputs", int'(outs()), 0);
    check("midreset_write_kept", int'(mem[6]), 3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("mid-load reset applied");

    // fresh load of 0xF, with a stray start mid-RECV -> ok, timing intact
    run_load(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 0, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("wr_q_empty", wr_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Bit-serial program loader that fills the 16×4 program memory from an external programming link, then verifies it. It receives 16 nibbles MSB-first, writes each into program memory through the memory's write port, then receives a 4-bit XOR checksum. It reads all 16 locations back through the memory's registered read port and reports pass/fail. It sits between the board-level programming pins and the program memory, and owns the memory's address/data/write-enable inputs while busy.

## Interface
- `DEPTH`, 16, number of program words; address width is log2(DEPTH).
- `DW`, 4, word width in bits.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored while `busy`.
- `ser_valid`  in  1  serial bit present.
- `ser_bit`  in  1  serial data bit, MSB of each nibble first.
- `ser_ready`  out  1  loader can accept a bit; a transfer occurs when `ser_valid && ser_ready`.
- `mem_addr`  out  4  program memory address.
- `mem_data`  out  4  program memory write data.
- `mem_we`  out  1  program memory write enable.
- `mem_rdata`  in  4  program memory read data; valid one cycle after `mem_addr` is presented.
- `busy`  out  1  load or verify in progress.
- `done`  out  1  level; verify finished, held until the next accepted `start`.
- `ok`  out  1  verify result; meaningful only while `done`=1.

## Operation
- States: IDLE, RECV, WRITE, CKSUM, VERIFY, DONE.
- **IDLE / DONE:**
  - `start`=1 → RECV.
  - Clears the word index, bit count, running XOR, `done` and `ok`.
- **RECV:**
  - `ser_ready`=1.
  - Each transfer shifts `ser_bit` into the nibble register LSB side, so the first bit ends up as bit 3.
  - The 4th transfer → WRITE.
- **WRITE:** exactly one cycle.
  - `ser_ready`=0, `mem_we`=1, `mem_addr`=index, `mem_data`=assembled nibble.
  - If index=15 → CKSUM, otherwise index+1 → RECV.
- **CKSUM:**
  - `ser_ready`=1.
  - Assembles 4 bits into the checksum register.
  - 4th transfer → VERIFY.
- **VERIFY:**
  - Issues read addresses 0..15 on consecutive cycles.
  - XOR-accumulates `mem_rdata` one cycle later.
  - After accumulating word 15 → DONE with `ok` = (readback XOR == received checksum).
- `busy` = 1 in RECV, WRITE, CKSUM, VERIFY.
- `ser_valid`=0 stalls RECV/CKSUM indefinitely with no timeout. Partial nibble and bit count are held.
- `start` while busy: ignored.
- `start` in DONE: restarts the load and clears `done`/`ok` on the next cycle.
- Index arithmetic: 4-bit, no wrap is ever reached. The transition out of WRITE at index 15 is decided before any increment.

## Timing
- Reset values:
  - `ser_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `busy`=0, `done`=0, `ok`=0.
  - State IDLE, all counters 0.
- `start` sampled at edge N → `busy`=1 and `ser_ready`=1 from cycle N+1.
- Uninterrupted load: 16×(4+1) + 4 = 84 cycles from first bit accepted to entering VERIFY.
- VERIFY lasts 17 cycles:
  - Cycles 0..15 present addresses 0..15.
  - Cycles 1..16 accumulate words 0..15; `mem_addr` holds 15 on cycle 16.
  - `done`=1 on the following cycle.
- `mem_we` is never high outside WRITE. `mem_addr` is 0 in IDLE/DONE.
- Reset mid-operation:
  - All outputs return to reset values on the next edge.
  - Words already written remain in memory.
  - A WRITE in the same cycle as reset is still performed by the memory, since `mem_we` was registered high.

## Structure
- Shared package `fourbee_pkg`: loader state encoding, `PROG_DEPTH`=16, `WORD_W`=4.
- Sub-module `nibble_deser`: 4-bit shift register plus 2-bit bit counter, with `shift`, `clear` and `full` signals. Instantiated once and shared by RECV and CKSUM.
- All other logic (FSM, index, XOR accumulators, verify pipeline register) lives in `prog_loader`.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles → all outputs 0, `ser_ready`=0; `start` never asserted → state unchanged for 100 cycles.
- Full load, nibbles 0x0..0xF, checksum 0x0, `ser_valid` tied high → 16 `mem_we` pulses with `mem_addr`=`mem_data`=0..15, `done`=1 with `ok`=1 exactly 84+17+1 cycles after `start`+1.
- Same load but checksum 0x5 → `done`=1, `ok`=0, memory contents still 0x0..0xF.
- Random `ser_valid` gaps (0–7 idle cycles between bits) with nibbles all 0xA, checksum 0x0 → identical writes, `ok`=1, no bit lost or duplicated.
- Reset asserted after 7 nibbles, then a fresh load of 0xF×16 with checksum 0x0 → addresses 0..15 rewritten with 0xF, `ok`=1.
- `start` pulsed mid-RECV → ignored, load completes normally; `start` in DONE → `done`/`ok` clear next cycle and a new load begins at address 0.
